// File: rtl/vga_timing_gen_pkg.sv
// Shared 800x600@72 timing constants and the 4:4:4 colour word layout used by
// the scan engine, the frame buffer and software bus-word packing.
package vga_timing_gen_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int COLOUR_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t RGB_BLACK = rgb444_t'(12'h000);

    function automatic rgb444_t to_rgb444(input logic [COLOUR_W-1:0] word);
        return rgb444_t'(word);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts through visible/front/sync/back regions and reports
// terminal count plus region flags decoded from the current count.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter int W       = X_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         in_sync,
    output logic         in_visible
);

    localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_START = VISIBLE + FRONT;
    localparam int SYNC_END   = VISIBLE + FRONT + SYNC;

    logic [W-1:0] cnt_r;

    // Position counter, wraps at TOTAL-1 when enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            if (cnt_r == W'(TOTAL - 1)) begin
                cnt_r <= {W{1'b0}};
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Region flags compared at 32 bits so a total of exactly 2^W still decodes
    assign cnt        = cnt_r;
    assign tc         = (cnt_r == W'(TOTAL - 1));
    assign in_visible = (32'(cnt_r) < VISIBLE);
    assign in_sync    = (32'(cnt_r) >= SYNC_START) && (32'(cnt_r) < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan engine: pixel clock-enable, x/y scan counters for the frame buffer,
// and a registered pin stage carrying colour, sync and the frame trigger.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   PIX_DIV   = 2,
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FRONT   = H_FRONT_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BACK    = H_BACK_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic                frame_trig,
    output logic                hsync,
    output logic                vsync,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (PIX_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (H_TOTAL > (1 << X_W)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit the x port");
    end
    if (V_TOTAL > (1 << Y_W)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit the y port");
    end

    logic [DIV_W-1:0] div_cnt_r;
    logic             pix_ce_s;
    logic             h_tc_s, h_in_sync_s, h_in_vis_s;
    logic             v_tc_unused_s, v_in_sync_s, v_in_vis_s;
    logic [X_W-1:0]   x_s;
    logic [Y_W-1:0]   y_s;
    logic             hsync_r, vsync_r, frame_trig_r;
    rgb444_t          rgb_r;

    assign pix_ce_s = (div_cnt_r == DIV_W'(PIX_DIV - 1));

    // Pixel clock-enable divider; stays at zero when PIX_DIV is 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (pix_ce_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(X_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .en(pix_ce_s),
        .cnt(x_s), .tc(h_tc_s), .in_sync(h_in_sync_s), .in_visible(h_in_vis_s)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(Y_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .en(pix_ce_s && h_tc_s),
        .cnt(y_s), .tc(v_tc_unused_s), .in_sync(v_in_sync_s), .in_visible(v_in_vis_s)
    );

    // Pin stage: one pixel behind x/y; frame_trig is a single-clk pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_r      <= ~SYNC_POL;
            vsync_r      <= ~SYNC_POL;
            rgb_r        <= RGB_BLACK;
            frame_trig_r <= 1'b0;
        end else begin
            frame_trig_r <= pix_ce_s && h_tc_s && (y_s == Y_W'(V_VISIBLE - 1));
            if (pix_ce_s) begin
                hsync_r <= h_in_sync_s ? SYNC_POL : ~SYNC_POL;
                vsync_r <= v_in_sync_s ? SYNC_POL : ~SYNC_POL;
                rgb_r   <= (h_in_vis_s && v_in_vis_s) ? to_rgb444(colour_in) : RGB_BLACK;
            end else begin
                hsync_r <= hsync_r;
                vsync_r <= vsync_r;
                rgb_r   <= rgb_r;
            end
        end
    end

    assign x          = x_s;
    assign y          = y_s;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign frame_trig = frame_trig_r;
    assign vga_r      = rgb_r.r;
    assign vga_g      = rgb_r.g;
    assign vga_b      = rgb_r.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a shrunken raster (15x11, PIX_DIV=2) for frame-level behaviour
// plus a default-timing PIX_DIV=1 instance for real line timing.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        force_white;
    logic [11:0] colour_in, colour_d1;
    logic [10:0] x, x1;
    logic [9:0]  y, y1;
    logic        frame_trig, ft1, hsync, hs1, vsync, vs1;
    logic [3:0]  r, g, b, r1, g1, b1;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    // Frame-buffer stand-in: colour is a combinational function of x/y
    assign colour_in = force_white ? 12'hFFF : {x[3:0], y[3:0], 4'hA};
    assign colour_d1 = 12'hFFF;

    // Small raster: H 8/2/3/2 = 15, V 6/2/2/1 = 11
    vga_timing_gen #(
        .PIX_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .colour_in(colour_in), .x(x), .y(y),
        .frame_trig(frame_trig), .hsync(hsync), .vsync(vsync),
        .vga_r(r), .vga_g(g), .vga_b(b)
    );

    vga_timing_gen #(.PIX_DIV(1)) dut_d1 (
        .clk(clk), .rst(rst), .colour_in(colour_d1), .x(x1), .y(y1),
        .frame_trig(ft1), .hsync(hs1), .vsync(vs1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1)
    );

    task automatic wait_xy(input logic [10:0] ex, input logic [9:0] ey, output bit found);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (x == ex && y == ey) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        force_white = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (x !== 11'd0) $display("FAIL reset_x: got %0d want 0", x); else pass_cnt++;
        total_cnt++; if (y !== 10'd0) $display("FAIL reset_y: got %0d want 0", y); else pass_cnt++;
        total_cnt++; if ({r, g, b} !== 12'h000) $display("FAIL reset_rgb: got %h want 000", {r, g, b}); else pass_cnt++;
        total_cnt++; if (hsync !== 1'b0 || vsync !== 1'b0) $display("FAIL reset_sync: got h=%b v=%b want 0 0", hsync, vsync); else pass_cnt++;
        total_cnt++; if (frame_trig !== 1'b0) $display("FAIL reset_trig: got %b want 0", frame_trig); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (x !== 11'd0) $display("FAIL release_x_edge1: got %0d want 0", x); else pass_cnt++;
        total_cnt++; if (x1 !== 11'd1) $display("FAIL release_div1_x_edge1: got %0d want 1", x1); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (x !== 11'd1) $display("FAIL release_x_edge2: got %0d want 1", x); else pass_cnt++;
        force_white = 1'b0;
    endtask

    task automatic test_colour();
        bit found;
        wait_xy(11'd6, 10'd3, found);
        total_cnt++; if (!found || {r, g, b} !== 12'h53A) $display("FAIL colour_5_3: got %h want 53A (found=%b)", {r, g, b}, found); else pass_cnt++;
        wait_xy(11'd8, 10'd5, found);
        total_cnt++; if (!found || {r, g, b} !== 12'h75A) $display("FAIL colour_last_vis: got %h want 75A (found=%b)", {r, g, b}, found); else pass_cnt++;
        wait_xy(11'd9, 10'd5, found);
        total_cnt++; if (!found || {r, g, b} !== 12'h000) $display("FAIL blank_h: got %h want 000 (found=%b)", {r, g, b}, found); else pass_cnt++;
        wait_xy(11'd3, 10'd7, found);
        total_cnt++; if (!found || {r, g, b} !== 12'h000) $display("FAIL blank_v: got %h want 000 (found=%b)", {r, g, b}, found); else pass_cnt++;
    endtask

    task automatic test_line_timing();
        bit found;
        int per, rises, high;
        logic prev;
        wait_xy(11'd10, 10'd7, found);
        total_cnt++; if (!found || hsync !== 1'b0) $display("FAIL hsync_pre: got %b want 0 (found=%b)", hsync, found); else pass_cnt++;
        wait_xy(11'd11, 10'd7, found);
        total_cnt++; if (!found || hsync !== 1'b1) $display("FAIL hsync_first: got %b want 1 (found=%b)", hsync, found); else pass_cnt++;
        wait_xy(11'd13, 10'd7, found);
        total_cnt++; if (!found || hsync !== 1'b1) $display("FAIL hsync_last: got %b want 1 (found=%b)", hsync, found); else pass_cnt++;
        wait_xy(11'd14, 10'd7, found);
        total_cnt++; if (!found || hsync !== 1'b0) $display("FAIL hsync_post: got %b want 0 (found=%b)", hsync, found); else pass_cnt++;
        per = 0; rises = 0; prev = hsync;
        for (int i = 0; i < 200 && rises < 2; i++) begin
            @(negedge clk);
            if (rises == 1) per++;
            if (hsync && !prev) rises++;
            prev = hsync;
        end
        total_cnt++; if (rises != 2 || per != 30) $display("FAIL hsync_period: got %0d clk want 30 (rises=%0d)", per, rises); else pass_cnt++;
        high = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hsync) high++;
        end
        total_cnt++; if (high != 6) $display("FAIL hsync_width: got %0d clk want 6", high); else pass_cnt++;
    endtask

    task automatic test_frame_timing();
        bit found;
        int per, rises, vhigh, trigs;
        logic prev;
        wait_xy(11'd0, 10'd8, found);
        total_cnt++; if (!found || vsync !== 1'b0) $display("FAIL vsync_pre: got %b want 0 (found=%b)", vsync, found); else pass_cnt++;
        wait_xy(11'd1, 10'd8, found);
        total_cnt++; if (!found || vsync !== 1'b1) $display("FAIL vsync_first: got %b want 1 (found=%b)", vsync, found); else pass_cnt++;
        wait_xy(11'd0, 10'd10, found);
        total_cnt++; if (!found || vsync !== 1'b1) $display("FAIL vsync_last: got %b want 1 (found=%b)", vsync, found); else pass_cnt++;
        wait_xy(11'd1, 10'd10, found);
        total_cnt++; if (!found || vsync !== 1'b0) $display("FAIL vsync_post: got %b want 0 (found=%b)", vsync, found); else pass_cnt++;
        per = 0; rises = 0; prev = vsync;
        for (int i = 0; i < 800 && rises < 2; i++) begin
            @(negedge clk);
            if (rises == 1) per++;
            if (vsync && !prev) rises++;
            prev = vsync;
        end
        total_cnt++; if (rises != 2 || per != 330) $display("FAIL vsync_period: got %0d clk want 330 (rises=%0d)", per, rises); else pass_cnt++;
        vhigh = 0; trigs = 0;
        for (int i = 0; i < 330; i++) begin
            @(negedge clk);
            if (vsync) vhigh++;
            if (frame_trig) trigs++;
        end
        total_cnt++; if (vhigh != 60) $display("FAIL vsync_width: got %0d clk want 60", vhigh); else pass_cnt++;
        total_cnt++; if (trigs != 1) $display("FAIL trig_per_frame: got %0d want 1", trigs); else pass_cnt++;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_trig) begin
                found = 1'b1;
                break;
            end
        end
        total_cnt++; if (!found || x !== 11'd0 || y !== 10'd6) $display("FAIL trig_pos: got x=%0d y=%0d want 0 6 (found=%b)", x, y, found); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (frame_trig !== 1'b0) $display("FAIL trig_width: got %b want 0", frame_trig); else pass_cnt++;
        wait_xy(11'd0, 10'd0, found);
        total_cnt++; if (!found || frame_trig !== 1'b0) $display("FAIL trig_at_wrap: got %b want 0 (found=%b)", frame_trig, found); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        bit found;
        int n;
        wait_xy(11'd12, 10'd8, found);
        total_cnt++; if (!found || hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL pre_reset_sync: got h=%b v=%b want 1 1 (found=%b)", hsync, vsync, found); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total_cnt++; if (x !== 11'd0 || y !== 10'd0) $display("FAIL midrst_xy: got x=%0d y=%0d want 0 0", x, y); else pass_cnt++;
        total_cnt++; if (hsync !== 1'b0 || vsync !== 1'b0) $display("FAIL midrst_sync: got h=%b v=%b want 0 0", hsync, vsync); else pass_cnt++;
        total_cnt++; if ({r, g, b} !== 12'h000 || frame_trig !== 1'b0) $display("FAIL midrst_rgb_trig: got rgb=%h trig=%b want 000 0", {r, g, b}, frame_trig); else pass_cnt++;
        total_cnt++; if (x1 !== 11'd0 || y1 !== 10'd0) $display("FAIL midrst_div1_xy: got x=%0d y=%0d want 0 0", x1, y1); else pass_cnt++;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (frame_trig) begin
                n = i;
                break;
            end
        end
        total_cnt++; if (n != 180) $display("FAIL midrst_trig_delay: got %0d clk want 180", n); else pass_cnt++;
    endtask

    task automatic test_pix_div1();
        bit found;
        int per, high;
        logic prev;
        found = 1'b0; prev = hs1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hs1 && !prev) begin
                found = 1'b1;
                break;
            end
            prev = hs1;
        end
        total_cnt++; if (!found || x1 !== 11'd857) $display("FAIL div1_hsync_start: got x=%0d want 857 (found=%b)", x1, found); else pass_cnt++;
        per = 0; high = 1; found = 1'b0; prev = hs1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            per++;
            if (hs1 && !prev) begin
                found = 1'b1;
                break;
            end
            if (hs1) high++;
            prev = hs1;
        end
        total_cnt++; if (!found || per != 1040) $display("FAIL div1_hsync_period: got %0d clk want 1040 (found=%b)", per, found); else pass_cnt++;
        total_cnt++; if (high != 120) $display("FAIL div1_hsync_width: got %0d clk want 120", high); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        force_white = 1'b1;
        test_reset();
        test_colour();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        test_pix_div1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display-side scan engine that sits directly downstream of the frame-buffer memory.
- Generates pixel-rate x/y scan coordinates, which the frame buffer reads combinationally and returns as a 12-bit colour.
- Registers that colour together with hsync/vsync/blanking onto the VGA pins.
- Emits a one-clock frame_trig pulse at the start of vertical blanking, so software and the frame buffer can do tear-free updates.

Parameters:
- PIX_DIV, 2, system clocks per pixel (clock-enable divider, ≥1); 100 MHz / 2 = 50 MHz for 800x600@72.
- H_VISIBLE, 800, active pixels per line.
- H_FRONT, 56, horizontal front porch (pixels).
- H_SYNC, 120, hsync pulse width (pixels).
- H_BACK, 64, horizontal back porch (pixels).
- V_VISIBLE, 600, active lines per frame.
- V_FRONT, 37, vertical front porch (lines).
- V_SYNC, 6, vsync pulse width (lines).
- V_BACK, 23, vertical back porch (lines).
- SYNC_POL, 1, sync active level (1 = active-high pulses).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- colour_in  input  12  {R[3:0],G[3:0],B[3:0]} from frame buffer for current x/y.
- x  output  11  current horizontal scan count 0..H_TOTAL-1, driven to frame buffer.
- y  output  10  current vertical scan count 0..V_TOTAL-1, driven to frame buffer.
- frame_trig  output  1  one-clk pulse at start of vertical blanking.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- vga_r  output  4  red.
- vga_g  output  4  green.
- vga_b  output  4  blue.

Behaviour:
- Derived values: H_TOTAL = sum of H_* = 1040; V_TOTAL = sum of V_* = 666.
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst == 0 sampled on the posedge of clk).
- Reset values: div_cnt = 0, x = 0, y = 0, frame_trig = 0, RGB = 0. hsync and vsync sit at their inactive level (~SYNC_POL).
- Pixel enable:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - pix_ce = (div_cnt == PIX_DIV-1). With PIX_DIV = 1, pix_ce is constantly 1.
  - All state below advances only on a clk edge with pix_ce = 1.
- Counters:
  - x increments and wraps at H_TOTAL-1 → 0.
  - On x wrap, y increments and wraps at V_TOTAL-1 → 0.
  - x and y are registers, so they are stable for a full pixel period.
- Output stage (1 pixel of latency, registered on pix_ce from the current x/y):
  - active = (x < H_VISIBLE) && (y < V_VISIBLE).
  - hsync = SYNC_POL when H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (856..975), else ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (637..642), else ~SYNC_POL.
  - RGB = colour_in when active, else 12'h000. Blanking is mandatory.
  - Net effect: pins show pixel (x,y) one pixel period after x/y present it, and sync stays aligned with colour.
- frame_trig:
  - High for exactly one clk when pix_ce = 1 and the counters step from (H_TOTAL-1, V_VISIBLE-1) to (0, V_VISIBLE).
  - Occurs once per frame.
- Boundary conditions:
  - Frame wrap at (1039,665) → (0,0) raises no frame_trig.
  - Reset asserted mid-frame forces all reset values on the next edge.
  - After reset releases, scanning restarts at (0,0), and the first pix_ce occurs PIX_DIV clocks after release.
- Frame buffer interface: colour_in is treated as combinational from x/y. No extra read-latency stage is allowed.
- Widths: synthesis must check that H_TOTAL ≤ 2^11 and V_TOTAL ≤ 2^10 (elaboration-time error otherwise).

Decomposition:
- Shared package holds:
  - 800x600@72 timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL).
  - The colour field layout {R,G,B} 4:4:4, reused by the frame buffer and by software bus-word packing.
- One natural sub-module, vga_axis_counter: parameterised visible/front/sync/back counter with enable, terminal-count output and in-sync/in-visible flags. It is instantiated twice (horizontal, enabled by pix_ce; vertical, enabled by horizontal terminal count).

Test Plan:
- Reset: hold rst = 0 for 5 clk with colour_in = 12'hFFF → x = 0, y = 0, RGB = 0, hsync = vsync = 0, frame_trig = 0. Release → x = 1 on the 2nd clk edge after release (PIX_DIV = 2).
- Line timing: count pix_ce between hsync rising edges → exactly 1040. hsync high for 120 pixels, first seen on the pix_ce after x = 856.
- Frame timing: vsync high for 6 lines. Period between vsync rises = 666 × 1040 × 2 = 1,385,280 clk. Exactly one frame_trig per frame, at y = 600, x = 0.
- Blanking/colour alignment: colour_in = {x[3:0],y[3:0],4'hA} → pixel (5,3) appears on pins as r = 5, g = 3, b = A one pixel after x = 5, y = 3. At x = 800..1039 or y ≥ 600, RGB = 0 regardless of colour_in.
- Mid-frame reset: assert rst at y = 300, x = 400 for 1 clk → next edge gives x = 0, y = 0, outputs at reset values. No frame_trig until 600 lines later.
- PIX_DIV = 1 variant → x advances every clk; hsync period = 1040 clk.
